// File: rtl/wb_buffer_ctrl.sv
// wb_buffer_ctrl: controller for the 4-entry L2 write-back (victim) buffer.
// Accepts evicted dirty lines and steers their writes into an external
// 4 x width line array. It coalesces repeat evictions of a buffered line,
// drains entries oldest-first to physical memory and answers lookups so that
// buffered lines can be forwarded.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push_valid/push_addr  evicted line offered by the cache (data goes to array)
//   push_ready            buffer can take the push this cycle (combinational)
//   lookup_addr           address probed by the cache
//   lookup_hit/index      a valid entry holds the probed line, and which one
//   arr_write/arr_index   array write enable and entry index
//   arr_data0..3          array entry contents
//   pmem_write            drain write request to memory
//   pmem_address/wdata    head entry line address and contents
//   pmem_resp             memory completed the current write
//   empty/full            occupancy flags
module wb_buffer_ctrl #(
    parameter int width      = 128,
    parameter int addr_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    input  logic [addr_width-1:0] push_addr,
    output logic                  push_ready,
    input  logic [addr_width-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [1:0]            lookup_index,
    output logic                  arr_write,
    output logic [1:0]            arr_index,
    input  logic [width-1:0]      arr_data0,
    input  logic [width-1:0]      arr_data1,
    input  logic [width-1:0]      arr_data2,
    input  logic [width-1:0]      arr_data3,
    output logic                  pmem_write,
    output logic [addr_width-1:0] pmem_address,
    output logic [width-1:0]      pmem_wdata,
    input  logic                  pmem_resp,
    output logic                  empty,
    output logic                  full
);

    localparam int TAG_W = addr_width - 4;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t            state, state_next;
    logic [3:0]        valid;
    logic [TAG_W-1:0]  tag [4];
    logic [1:0]        rd_ptr, wr_ptr;
    logic [2:0]        count;

    logic [TAG_W-1:0]  push_tag, lookup_tag;
    logic              match;
    logic [1:0]        match_idx;
    logic              accept, accept_new, drain_done;

    assign push_tag   = push_addr[addr_width-1:4];
    assign lookup_tag = lookup_addr[addr_width-1:4];

    // At most one valid entry per tag, so the first hit found is the only one.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (valid[i] && (tag[i] == push_tag)) begin
                match     = 1'b1;
                match_idx = i[1:0];
            end
        end
    end

    always_comb begin
        lookup_hit   = 1'b0;
        lookup_index = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (valid[i] && (tag[i] == lookup_tag)) begin
                lookup_hit   = 1'b1;
                lookup_index = i[1:0];
            end
        end
    end

    // A coalescing push onto the line currently in flight must wait for
    // pmem_resp; otherwise memory could receive a mix of old and new data.
    // No bypass from pmem_resp: a full buffer stays not-ready that cycle.
    always_comb begin
        if (match && (match_idx == rd_ptr) && (state == DRAIN)) begin
            push_ready = 1'b0;
        end else if (match) begin
            push_ready = 1'b1;
        end else begin
            push_ready = (count < 3'd4);
        end
    end

    assign accept     = push_valid & push_ready;
    assign accept_new = accept & ~match;
    assign drain_done = (state == DRAIN) & pmem_resp;

    assign arr_write  = accept;
    assign arr_index  = match ? match_idx : wr_ptr;

    assign pmem_write   = (state == DRAIN);
    assign pmem_address = {tag[rd_ptr], 4'b0000};

    always_comb begin
        case (rd_ptr)
            2'd0:    pmem_wdata = arr_data0;
            2'd1:    pmem_wdata = arr_data1;
            2'd2:    pmem_wdata = arr_data2;
            default: pmem_wdata = arr_data3;
        endcase
    end

    assign empty = (count == 3'd0);
    assign full  = (count == 3'd4);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != 3'd0) state_next = DRAIN;
            DRAIN:   if (pmem_resp)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new entry and a drain completion never target the same slot: in DRAIN
    // count > 0, so wr_ptr == rd_ptr only when full, and then no new entry is
    // accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                tag[i] <= '0;
            end
        end else begin
            if (drain_done) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 2'd1;
            end
            if (accept_new) begin
                tag[wr_ptr]   <= push_tag;
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 2'd1;
            end
            count <= count + {2'b00, accept_new} - {2'b00, drain_done};
        end
    end

endmodule

// File: doc/wb_buffer_ctrl.md
Name: wb_buffer_ctrl

Overview:
- Controller for the 4-entry, 128-bit line array that serves as the L2 write-back (victim) buffer.
- Accepts evicted dirty lines from the cache and steers their writes into the array.
- Tracks per-entry line address and valid bits, and coalesces repeat evictions of the same line.
- Drains entries oldest-first to physical memory over the pmem handshake, and answers cache lookups so buffered lines can be forwarded.

Parameters:
width, 128, line width in bits (array entry width, pmem_wdata width)
addr_width, 16, byte address width; line offset is addr[3:0], tag is addr[addr_width-1:4]

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
push_valid  in  1  cache presents an evicted line (data goes straight to array datain)
push_addr  in  addr_width  address of evicted line; low 4 bits ignored
push_ready  out  1  buffer can accept push this cycle (combinational)
lookup_addr  in  addr_width  address the cache is probing
lookup_hit  out  1  a valid entry holds lookup_addr's line (combinational)
lookup_index  out  2  entry index of hit; 0 when no hit
arr_write  out  1  array write enable
arr_index  out  2  array write index
arr_data0..arr_data3  in  width each  array entry contents
pmem_write  out  1  drain write request to memory
pmem_address  out  addr_width  {tag of head entry, 4'b0}
pmem_wdata  out  width  contents of head entry (mux of arr_data0..3 by rd_ptr)
pmem_resp  in  1  memory completed current write
empty  out  1  count == 0
full  out  1  count == 4

Behaviour:
- State:
  - valid[3:0] and tag[3:0] per entry.
  - rd_ptr and wr_ptr are 2-bit and wrap 3->0.
  - count is 3-bit, range 0..4.
  - FSM is {IDLE, DRAIN}.
- Reset (async, rst_n low):
  - valid=0, rd_ptr=wr_ptr=0, count=0, FSM=IDLE.
  - Output values during reset: pmem_write=0, push_ready=1, empty=1, full=0, lookup_hit=0.
  - Array contents are not cleared.
- Reset mid-DRAIN: pmem_write drops immediately; the in-flight memory write is abandoned.
- Coalesce match (match): push_addr tag equals a valid entry's tag. At most one entry per tag is ever valid.
- push_ready:
  - 0 if match hits the head entry while FSM=DRAIN; the line is in flight, so the push stalls until pmem_resp.
  - Else 1 if match.
  - Else 1 if count<4.
  - Else 0.
  - No same-cycle bypass: full with pmem_resp in the same cycle still gives push_ready=0.
- Accept = push_valid & push_ready; arr_write = accept (combinational), so the array latches data on the same edge.
- arr_index = matching entry index if match, else wr_ptr.
- On accept with match: overwrite data in place; tag, valid, pointers and count are unchanged.
- On accept without match: tag[wr_ptr] <= push tag, valid[wr_ptr] <= 1, wr_ptr++, count++.
- FSM:
  - IDLE -> DRAIN when count>0 at the clock edge. pmem_write is a registered-state output, asserted the cycle after the entry becomes valid at the earliest.
  - DRAIN: pmem_write=1. pmem_address and pmem_wdata come from rd_ptr and are held stable until pmem_resp.
  - DRAIN, pmem_resp=1: valid[rd_ptr] <= 0, rd_ptr++, count--, -> IDLE. There is a mandatory one-cycle gap between consecutive drains.
- Simultaneous new-entry accept and pmem_resp: count stays unchanged (+1-1), and both pointers advance.
- Lookup:
  - Combinational tag compare against all valid entries.
  - Includes the entry currently draining, up to and including the pmem_resp cycle.
  - A push accepted in cycle N is visible to lookup from N+1.
- pmem_resp outside DRAIN is ignored.

Test Plan:
- Reset then idle:
  - rst_n low 3 cycles -> empty=1, full=0, push_ready=1, pmem_write=0, lookup_hit=0.
  - Release with no pushes -> all outputs unchanged for 10 cycles.
- Single push:
  - Push 0x1230 with data A, pmem_resp held low.
  - -> arr_write=1, arr_index=0 that cycle.
  - Next cycle lookup 0x1238 -> hit, index 0.
  - pmem_write=1, pmem_address=0x1230, pmem_wdata=A.
  - pmem_resp pulsed after 5 cycles -> empty=1, lookup misses.
- Fill and wrap:
  - Push 0x0010, 0x0020, 0x0030, 0x0040 back-to-back with pmem_resp low -> full=1, push_ready=0 for new 0x0050.
  - Resp for 0x0010 -> next cycle 0x0050 accepted at arr_index=0 (wrap).
  - Drain order 0x0020, 0x0030, 0x0040, 0x0050.
- Coalesce:
  - Push 0x0100 then 0x0200; re-push 0x0200 with data B while 0x0100 drains -> arr_index=1, count stays 2.
  - Later drain of 0x0200 carries B.
- Head stall:
  - While 0x0100 is draining, push 0x0100 -> push_ready=0.
  - After pmem_resp -> accepted next cycle as a new entry, and drained again.
- Async reset mid-drain:
  - Assert rst_n low between clock edges while pmem_write=1 with count=3 -> pmem_write=0 before the next edge.
  - After release: empty=1, first push goes to index 0.
